// File: rtl/wb_ddr2_line_buffer.sv
// Single-line (16-byte) read buffer in front of one DDR2 arbiter Wishbone port.
// Read misses fill the whole line with a 4-beat incrementing burst; writes pass straight through.
module wb_ddr2_line_buffer (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  input  logic        flush_i
);

  // state | meaning
  // IDLE  | waiting for an upstream request
  // FILL  | 4-beat downstream burst loading the line
  // WR    | single classic write passed downstream
  // ACK   | one-cycle upstream ack, wbs_dat_o already loaded
  // ERR   | one-cycle upstream error after a downstream err/rty
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    WR   = 3'd2,
    ACK  = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        valid;
  logic [27:0] tag;
  logic [1:0]  cnt;
  logic        flush_pend;
  logic [31:0] line_buf [0:3];
  logic [31:0] buf_next [0:3];

  logic req;
  logic hit;
  logic fault;
  logic beat_ok;
  logic unused_ok;

  assign req     = wbs_cyc_i & wbs_stb_i;
  assign hit     = valid & (tag == wbs_adr_i[31:4]);
  assign fault   = wbm_err_i | wbm_rty_i;
  assign beat_ok = wbm_ack_i & ~fault;

  // Burst type hints from upstream carry no meaning here; every access is classic.
  assign unused_ok = ^{wbs_cti_i, wbs_bte_i};

  always_ff @(posedge wb_clk) begin
    if (wb_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (wbs_we_i)  state_next = WR;
          else if (hit)  state_next = ACK;
          else           state_next = FILL;
        end
      end
      FILL: begin
        if (fault)                      state_next = ERR;
        else if (wbm_ack_i && cnt == 2'd3) state_next = ACK;
      end
      WR: begin
        if (fault)          state_next = ERR;
        else if (wbm_ack_i) state_next = ACK;
      end
      ACK:     state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wbm_adr_o = 32'h0;
    wbm_dat_o = 32'h0;
    wbm_sel_o = 4'h0;
    wbm_we_o  = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_cti_o = 3'b000;
    wbm_bte_o = 2'b00;
    wbs_ack_o = 1'b0;
    wbs_err_o = 1'b0;
    wbs_rty_o = 1'b0;
    case (state)
      FILL: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = {tag, cnt, 2'b00};
        wbm_cti_o = (cnt == 2'd3) ? 3'b111 : 3'b010;
      end
      WR: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_adr_o = wbs_adr_i;
        wbm_dat_o = wbs_dat_i;
        wbm_sel_o = wbs_sel_i;
      end
      ACK:     wbs_ack_o = req;
      ERR:     wbs_err_o = 1'b1;
      default: ;
    endcase
  end

  // Next line contents, also used to load wbs_dat_o so the final fill beat and a write merge are visible.
  always_comb begin
    for (int i = 0; i < 4; i++) buf_next[i] = line_buf[i];
    if (state == FILL && beat_ok) buf_next[cnt] = wbm_dat_i;
    if (state == WR && beat_ok && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) buf_next[wbs_adr_i[3:2]][8*b +: 8] = wbs_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    for (int i = 0; i < 4; i++) line_buf[i] <= buf_next[i];
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      valid      <= 1'b0;
      tag        <= 28'h0;
      cnt        <= 2'd0;
      flush_pend <= 1'b0;
      wbs_dat_o  <= 32'h0;
    end else begin
      if (state_next == ACK) wbs_dat_o <= buf_next[wbs_adr_i[3:2]];
      case (state)
        IDLE: begin
          if (req && !wbs_we_i && !hit) begin
            cnt   <= 2'd0;
            tag   <= wbs_adr_i[31:4];
            valid <= 1'b0;
          end
          if (flush_i) valid <= 1'b0;
        end
        FILL: begin
          if (flush_i) flush_pend <= 1'b1;
          if (fault) begin
            valid      <= 1'b0;
            flush_pend <= 1'b0;
          end else if (wbm_ack_i) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              valid      <= ~(flush_pend | flush_i);
              flush_pend <= 1'b0;
            end
          end
        end
        WR: begin
          if (flush_i) flush_pend <= 1'b1;
          if (fault) begin
            valid      <= 1'b0;
            flush_pend <= 1'b0;
          end else if (wbm_ack_i) begin
            if (flush_pend || flush_i) valid <= 1'b0;
            flush_pend <= 1'b0;
          end
        end
        ACK, ERR: begin
          if (flush_i) valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ddr2_line_buffer.sv
// Bench for wb_ddr2_line_buffer: directed scenarios plus randomized traffic
// checked against a line-level cache model and a zero-wait downstream memory.
module tb_wb_ddr2_line_buffer;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic        flush_i;

  wb_ddr2_line_buffer dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .flush_i(flush_i)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  logic [31:0] mem [0:255];
  logic        err_arm;
  beat_t       beats [$];
  beat_t       mon_b;

  int checks = 0;
  int errors = 0;

  // Line-level model of the buffer
  logic        m_valid;
  logic [27:0] m_tag;
  logic [31:0] m_line [0:3];

  // Zero-wait downstream memory; optional error injected on the third fill beat
  always_comb begin
    wbm_err_i = wbm_cyc_o & wbm_stb_o & err_arm & ~wbm_we_o & (wbm_adr_o[3:2] == 2'd2);
    wbm_ack_i = wbm_cyc_o & wbm_stb_o & ~wbm_err_i;
    wbm_rty_i = 1'b0;
    wbm_dat_i = mem[wbm_adr_o[9:2]];
  end

  always @(posedge wb_clk) begin
    if (!wb_rst && wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
      mon_b.we  = wbm_we_o;
      mon_b.sel = wbm_sel_o;
      mon_b.cti = wbm_cti_o;
      mon_b.bte = wbm_bte_o;
      mon_b.adr = wbm_adr_o;
      mon_b.dat = wbm_dat_o;
      beats.push_back(mon_b);
    end
  end

  task automatic model_read(input logic [31:0] a, output logic [31:0] exp, output logic miss);
    miss = !(m_valid && m_tag == a[31:4]);
    if (miss) begin
      for (int k = 0; k < 4; k++) m_line[k] = mem[{a[9:4], 2'(k)}];
      m_tag   = a[31:4];
      m_valid = 1'b1;
    end
    exp = m_line[a[3:2]];
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
        if (m_valid && m_tag == a[31:4]) m_line[a[3:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int flush_at, output logic [31:0] rdata, output int lat,
                     output logic got_ack, output logic got_err);
    @(negedge wb_clk);
    wbs_we_i = we; wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    lat = 0; rdata = 32'h0; got_ack = 1'b0; got_err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge wb_clk);
      if (wbs_ack_o || wbs_err_o) begin
        lat = i; rdata = wbs_dat_o; got_ack = wbs_ack_o; got_err = wbs_err_o;
        break;
      end
      flush_i = (i == flush_at);
    end
    flush_i = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL txn_timeout adr=%h: no ack/err within 20 cycles", a);
    end
  endtask

  task automatic pulse_flush();
    @(negedge wb_clk); flush_i = 1'b1;
    @(negedge wb_clk); flush_i = 1'b0;
    m_valid = 1'b0;
  endtask

  // Full read with model update and burst/latency/data checks
  task automatic test_read(input string name, input logic [31:0] a, input int flush_at);
    logic [31:0] exp, rd;
    logic miss, ack, err;
    int lat, n0;
    model_read(a, exp, miss);
    n0 = beats.size();
    txn(1'b0, a, 32'h0, 4'hF, flush_at, rd, lat, ack, err);
    if (flush_at != 0) m_valid = 1'b0;
    checks++;
    if (rd !== exp || !ack) begin
      errors++; $display("FAIL %s_data adr=%h got=%h ack=%b want=%h", name, a, rd, ack, exp);
    end
    checks++;
    if (lat != (miss ? 5 : 1)) begin
      errors++; $display("FAIL %s_latency adr=%h got=%0d want=%0d", name, a, lat, miss ? 5 : 1);
    end
    checks++;
    if (beats.size() - n0 != (miss ? 4 : 0)) begin
      errors++; $display("FAIL %s_beats adr=%h got=%0d want=%0d", name, a, beats.size() - n0, miss ? 4 : 0);
    end else if (miss) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (beats[n0+k].adr !== {a[31:4], 2'(k), 2'b00} || beats[n0+k].cti !== (k == 3 ? 3'b111 : 3'b010) ||
            beats[n0+k].sel !== 4'hF || beats[n0+k].we !== 1'b0 || beats[n0+k].bte !== 2'b00) begin
          errors++;
          $display("FAIL %s_beat%0d got adr=%h cti=%b sel=%h we=%b bte=%b want adr=%h", name, k,
                   beats[n0+k].adr, beats[n0+k].cti, beats[n0+k].sel, beats[n0+k].we, beats[n0+k].bte,
                   {a[31:4], 2'(k), 2'b00});
        end
      end
    end
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o, wbm_bte_o, wbm_sel_o} !== 13'h0) begin
      errors++; $display("FAIL %s_wbm_idle got cyc=%b stb=%b cti=%b sel=%h want all 0", name,
                         wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_sel_o);
    end
  endtask

  task automatic test_write(input string name, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int flush_at);
    logic [31:0] rd;
    logic ack, err;
    int lat, n0;
    n0 = beats.size();
    txn(1'b1, a, d, s, flush_at, rd, lat, ack, err);
    model_write(a, d, s);
    if (flush_at != 0) m_valid = 1'b0;
    checks++;
    if (lat != 2 || !ack) begin
      errors++; $display("FAIL %s_latency adr=%h got=%0d ack=%b want=2", name, a, lat, ack);
    end
    checks++;
    if (beats.size() - n0 != 1) begin
      errors++; $display("FAIL %s_beats adr=%h got=%0d want=1", name, a, beats.size() - n0);
    end else if (beats[n0].adr !== a || beats[n0].dat !== d || beats[n0].sel !== s ||
                 beats[n0].we !== 1'b1 || beats[n0].cti !== 3'b000) begin
      errors++;
      $display("FAIL %s_beat got adr=%h dat=%h sel=%h we=%b cti=%b want adr=%h dat=%h sel=%h we=1 cti=000",
               name, beats[n0].adr, beats[n0].dat, beats[n0].sel, beats[n0].we, beats[n0].cti, a, d, s);
    end
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    checks++;
    if ({wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_dat_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o} !== 0) begin
      errors++; $display("FAIL reset_outputs got ack=%b err=%b dat=%h cyc=%b want all 0",
                         wbs_ack_o, wbs_err_o, wbs_dat_o, wbm_cyc_o);
    end
    // Reset in the middle of a fill
    @(negedge wb_clk);
    wbs_we_i = 1'b0; wbs_adr_i = 32'h100; wbs_sel_i = 4'hF; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    repeat (2) @(negedge wb_clk);
    checks++;
    if (wbm_cyc_o !== 1'b1) begin
      errors++; $display("FAIL reset_fill_started got cyc=%b want 1", wbm_cyc_o);
    end
    wb_rst = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge wb_clk);
      checks++;
      if ({wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_dat_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o,
           wbm_bte_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 0) begin
        errors++; $display("FAIL reset_mid_fill_c%0d got ack=%b err=%b dat=%h cyc=%b stb=%b adr=%h want all 0",
                           c, wbs_ack_o, wbs_err_o, wbs_dat_o, wbm_cyc_o, wbm_stb_o, wbm_adr_o);
      end
    end
    wb_rst = 1'b0;
    m_valid = 1'b0;
    test_read("reset_reread", 32'h100, 0);
  endtask

  task automatic test_basic();
    pulse_flush();
    test_read("fill_104", 32'h104, 0);
    test_read("hit_10c", 32'h10C, 0);
    test_write("wr_104", 32'h104, 32'hAAAABBBB, 4'b0011, 0);
    test_read("hit_104_merged", 32'h104, 0);
    checks++;
    if (m_line[1] !== 32'h0000BBBB) begin
      errors++; $display("FAIL model_merge got=%h want=0000bbbb", m_line[1]);
    end
  endtask

  task automatic test_error();
    logic [31:0] rd;
    logic ack, err;
    int lat, n0;
    pulse_flush();
    err_arm = 1'b1;
    n0 = beats.size();
    txn(1'b0, 32'h100, 32'h0, 4'hF, 0, rd, lat, ack, err);
    err_arm = 1'b0;
    checks++;
    if (!err || ack || lat != 4) begin
      errors++; $display("FAIL err_response got err=%b ack=%b lat=%0d want err=1 ack=0 lat=4", err, ack, lat);
    end
    checks++;
    if (beats.size() - n0 != 2) begin
      errors++; $display("FAIL err_beats got=%0d want=2", beats.size() - n0);
    end
    @(negedge wb_clk);
    checks++;
    if (wbs_err_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      errors++; $display("FAIL err_one_cycle got err=%b cyc=%b want 0 0", wbs_err_o, wbm_cyc_o);
    end
    m_valid = 1'b0;
    test_read("err_reread", 32'h100, 0);
  endtask

  task automatic test_flush();
    test_read("flush_fill", 32'h128, 2);
    test_read("flush_reread", 32'h124, 0);
    test_write("flush_wr_hit", 32'h120, 32'h5A5A1234, 4'b1111, 1);
    test_read("after_wr_flush", 32'h120, 0);
  endtask

  task automatic test_cyc_drop();
    int acks;
    logic [31:0] exp;
    logic miss;
    pulse_flush();
    @(negedge wb_clk);
    wbs_we_i = 1'b0; wbs_adr_i = 32'h134; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    repeat (2) @(negedge wb_clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge wb_clk);
      if (wbs_ack_o) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL cyc_drop_ack got=%0d acks want=0", acks);
    end
    model_read(32'h130, exp, miss);
    test_read("cyc_drop_hit", 32'h138, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      a = 32'h100 + ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 9) == 0) pulse_flush();
      if ($urandom_range(0, 2) == 0)
        test_write("rnd_wr", a, $urandom, 4'($urandom_range(1, 15)), 0);
      else
        test_read("rnd_rd", a, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h40] = 32'h11; mem[8'h41] = 32'h22; mem[8'h42] = 32'h33; mem[8'h43] = 32'h44;
    err_arm = 1'b0; flush_i = 1'b0; m_valid = 1'b0; m_tag = 28'h0;
    for (int k = 0; k < 4; k++) m_line[k] = 32'h0;
    wbs_adr_i = 32'h0; wbs_dat_i = 32'h0; wbs_sel_i = 4'h0; wbs_we_i = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_cti_i = 3'b000; wbs_bte_i = 2'b00;
    wb_rst = 1'b1;
    test_reset();
    test_basic();
    test_error();
    test_flush();
    test_cyc_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
